// File: rtl/cv32e40p_hwloop_ctrl_if.sv
// Bundle between the hardware-loop controller and the ID stage, loop register file and IF stage.
// The slave modport is the controller; the master modport drives it.
interface cv32e40p_hwloop_ctrl_if #(
    parameter int N_REGS     = 2,
    parameter int N_REG_BITS = $clog2(N_REGS)
);
    logic [31:0]              pc_id;
    logic                     id_valid;
    logic [N_REGS-1:0][31:0]  hwlp_start_addr;
    logic [N_REGS-1:0][31:0]  hwlp_end_addr;
    logic [N_REGS-1:0][31:0]  hwlp_counter;
    logic [2:0]               hwlp_we;
    logic [N_REG_BITS-1:0]    hwlp_regid;
    logic                     fetch_ready;
    logic                     flush;
    logic [N_REGS-1:0]        hwlp_dec_cnt;
    logic                     hwlp_jump;
    logic [31:0]              hwlp_targ_addr;
    logic                     hwlp_kill;

    modport master (
        output pc_id, id_valid, hwlp_start_addr, hwlp_end_addr, hwlp_counter,
        output hwlp_we, hwlp_regid, fetch_ready, flush,
        input  hwlp_dec_cnt, hwlp_jump, hwlp_targ_addr, hwlp_kill
    );

    modport slave (
        input  pc_id, id_valid, hwlp_start_addr, hwlp_end_addr, hwlp_counter,
        input  hwlp_we, hwlp_regid, fetch_ready, flush,
        output hwlp_dec_cnt, hwlp_jump, hwlp_targ_addr, hwlp_kill
    );
endinterface

// File: rtl/cv32e40p_hwloop_ctrl.sv
// Hardware-loop controller: detects retirement at a loop end address, requests the counter
// decrement and holds an IF redirect to the loop start until fetch accepts it.
module cv32e40p_hwloop_ctrl #(
    parameter int N_REGS     = 2,
    parameter int N_REG_BITS = $clog2(N_REGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cv32e40p_hwloop_ctrl_if.slave hwlp
);

    typedef enum logic {
        IDLE = 1'b0,
        JUMP = 1'b1
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  sel_valid;
    logic [N_REG_BITS-1:0] sel_idx;
    logic                  collision;
    logic                  targ_load;
    logic [N_REGS-1:0]     dec_cnt;
    logic [31:0]           targ_q;

    // Descending scan so the lowest-index (innermost) matching loop wins.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int k = N_REGS - 1; k >= 0; k--) begin
            if (hwlp.id_valid && (hwlp.pc_id == hwlp.hwlp_end_addr[k]) &&
                (hwlp.hwlp_counter[k] != 32'd0)) begin
                sel_valid = 1'b1;
                sel_idx   = N_REG_BITS'(k);
            end
        end
    end

    assign collision = (hwlp.hwlp_we != 3'b000) && (hwlp.hwlp_regid == sel_idx);

    always_comb begin
        state_next = state;
        targ_load  = 1'b0;
        dec_cnt    = '0;
        case (state)
            IDLE: begin
                if (sel_valid && !hwlp.flush && !collision) begin
                    dec_cnt[sel_idx] = 1'b1;
                    if (hwlp.hwlp_counter[sel_idx] > 32'd1) begin
                        state_next = JUMP;
                        targ_load  = 1'b1;
                    end
                end
            end
            JUMP: begin
                if (hwlp.flush || hwlp.fetch_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            targ_q <= 32'h0;
        end else begin
            state <= state_next;
            if (targ_load) begin
                targ_q <= hwlp.hwlp_start_addr[sel_idx];
            end
        end
    end

    // Decrement is combinational, so it is also masked directly by reset.
    assign hwlp.hwlp_dec_cnt   = rst_n ? dec_cnt : '0;
    assign hwlp.hwlp_jump      = (state == JUMP);
    assign hwlp.hwlp_kill      = (state == JUMP);
    assign hwlp.hwlp_targ_addr = targ_q;

endmodule

// File: tb/tb_cv32e40p_hwloop_ctrl.sv
// Directed bench for cv32e40p_hwloop_ctrl: a table of single-cycle vectors followed by
// hand-written backpressure, flush and reset sequences.
module tb_cv32e40p_hwloop_ctrl;

    logic clk;
    logic rst_n;
    int   check_count;
    int   error_count;

    cv32e40p_hwloop_ctrl_if #(.N_REGS(2)) hw_if ();

    cv32e40p_hwloop_ctrl #(.N_REGS(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hwlp  (hw_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic [31:0] s0, e0, c0, s1, e1, c1;
        logic [2:0]  we;
        logic        regid;
        logic        fr;
        logic        flush;
        logic [1:0]  exp_dec;
        logic        exp_jump;
        logic [31:0] exp_targ;
    } vec_t;

    vec_t vecs [19];

    function automatic vec_t mk(input logic [31:0] pc, input logic valid,
                                input logic [31:0] s0, e0, c0, s1, e1, c1,
                                input logic [2:0] we, input logic regid,
                                input logic fr, input logic flush,
                                input logic [1:0] exp_dec, input logic exp_jump,
                                input logic [31:0] exp_targ);
        vec_t v;
        v.pc = pc; v.valid = valid;
        v.s0 = s0; v.e0 = e0; v.c0 = c0;
        v.s1 = s1; v.e1 = e1; v.c1 = c1;
        v.we = we; v.regid = regid; v.fr = fr; v.flush = flush;
        v.exp_dec = exp_dec; v.exp_jump = exp_jump; v.exp_targ = exp_targ;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        hw_if.pc_id              = v.pc;
        hw_if.id_valid           = v.valid;
        hw_if.hwlp_start_addr[0] = v.s0;
        hw_if.hwlp_end_addr[0]   = v.e0;
        hw_if.hwlp_counter[0]    = v.c0;
        hw_if.hwlp_start_addr[1] = v.s1;
        hw_if.hwlp_end_addr[1]   = v.e1;
        hw_if.hwlp_counter[1]    = v.c1;
        hw_if.hwlp_we            = v.we;
        hw_if.hwlp_regid         = v.regid;
        hw_if.fetch_ready        = v.fr;
        hw_if.flush              = v.flush;
    endtask

    // Drive at the negedge, check decrement before the edge and redirect after it.
    task automatic runVector(input string tag, input vec_t v);
        @(negedge clk);
        applyStimulus(v);
        #1;
        checkOutput({tag, " dec"}, 32'(hw_if.hwlp_dec_cnt), 32'(v.exp_dec));
        @(posedge clk);
        #1;
        checkOutput({tag, " jump"}, 32'(hw_if.hwlp_jump), 32'(v.exp_jump));
        checkOutput({tag, " kill"}, 32'(hw_if.hwlp_kill), 32'(v.exp_jump));
        checkOutput({tag, " targ"}, hw_if.hwlp_targ_addr, v.exp_targ);
    endtask

    initial begin
        vec_t idle_v;
        vec_t match_v;
        check_count = 0;
        error_count = 0;

        //              pc        vld s0       e0       c0            s1       e1       c1  we      rg  fr    fl    dec    jmp   targ
        vecs[0]  = mk(32'h000, 0, 32'h100, 32'h110, 32'd3,        32'h180, 32'h1F0, 0, 3'b000, 0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h000);
        vecs[1]  = mk(32'h110, 1, 32'h100, 32'h110, 32'd3,        32'h180, 32'h1F0, 0, 3'b000, 0, 1'b1, 1'b0, 2'b01, 1'b1, 32'h100);
        vecs[2]  = mk(32'h100, 0, 32'h100, 32'h110, 32'd2,        32'h180, 32'h1F0, 0, 3'b000, 0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h100);
        vecs[3]  = mk(32'h110, 1, 32'h100, 32'h110, 32'd2,        32'h180, 32'h1F0, 0, 3'b000, 0, 1'b1, 1'b0, 2'b01, 1'b1, 32'h100);
        vecs[4]  = mk(32'h100, 0, 32'h100, 32'h110, 32'd1,        32'h180, 32'h1F0, 0, 3'b000, 0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h100);
        vecs[5]  = mk(32'h110, 1, 32'h100, 32'h110, 32'd1,        32'h180, 32'h1F0, 0, 3'b000, 0, 1'b1, 1'b0, 2'b01, 1'b0, 32'h100);
        vecs[6]  = mk(32'h110, 1, 32'h100, 32'h110, 32'd0,        32'h180, 32'h1F0, 0, 3'b000, 0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h100);
        vecs[7]  = mk(32'h200, 1, 32'h1C0, 32'h200, 32'd1,        32'h1A0, 32'h200, 5, 3'b000, 0, 1'b1, 1'b0, 2'b01, 1'b0, 32'h100);
        vecs[8]  = mk(32'h200, 1, 32'h1C0, 32'h200, 32'd0,        32'h1A0, 32'h200, 5, 3'b000, 0, 1'b1, 1'b0, 2'b10, 1'b1, 32'h1A0);
        vecs[9]  = mk(32'h1A0, 0, 32'h1C0, 32'h200, 32'd0,        32'h1A0, 32'h200, 4, 3'b000, 0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h1A0);
        vecs[10] = mk(32'h110, 1, 32'h100, 32'h110, 32'd3,        32'h180, 32'h1F0, 0, 3'b100, 0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h1A0);
        vecs[11] = mk(32'h110, 1, 32'h100, 32'h110, 32'd3,        32'h180, 32'h1F0, 0, 3'b100, 1, 1'b1, 1'b0, 2'b01, 1'b1, 32'h100);
        vecs[12] = mk(32'h100, 0, 32'h100, 32'h110, 32'd2,        32'h180, 32'h1F0, 0, 3'b000, 0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h100);
        vecs[13] = mk(32'h110, 1, 32'h100, 32'h110, 32'hFFFF_FFFF, 32'h180, 32'h1F0, 0, 3'b000, 0, 1'b1, 1'b0, 2'b01, 1'b1, 32'h100);
        vecs[14] = mk(32'h100, 0, 32'h100, 32'h110, 32'hFFFF_FFFE, 32'h180, 32'h1F0, 0, 3'b000, 0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h100);
        vecs[15] = mk(32'h110, 1, 32'h100, 32'h110, 32'd3,        32'h180, 32'h1F0, 0, 3'b000, 0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h100);
        vecs[16] = mk(32'h1F0, 1, 32'h100, 32'h110, 32'd3,        32'h180, 32'h1F0, 2, 3'b000, 0, 1'b1, 1'b0, 2'b10, 1'b1, 32'h180);
        vecs[17] = mk(32'h180, 0, 32'h100, 32'h110, 32'd3,        32'h180, 32'h1F0, 1, 3'b000, 0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h180);
        vecs[18] = mk(32'h110, 0, 32'h100, 32'h110, 32'd3,        32'h180, 32'h1F0, 1, 3'b000, 0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h180);

        rst_n = 1'b0;
        applyStimulus(vecs[1]);
        #2;
        checkOutput("reset dec", 32'(hw_if.hwlp_dec_cnt), 32'h0);
        checkOutput("reset jump", 32'(hw_if.hwlp_jump), 32'h0);
        checkOutput("reset kill", 32'(hw_if.hwlp_kill), 32'h0);
        checkOutput("reset targ", hw_if.hwlp_targ_addr, 32'h0);
        @(negedge clk);
        applyStimulus(vecs[0]);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            runVector($sformatf("vec%0d", i), vecs[i]);
        end

        // Backpressure: redirect held for four cycles while fetch stalls, matches ignored.
        idle_v  = mk(32'h000, 0, 32'h140, 32'h110, 32'd3, 32'h180, 32'h1F0, 0, 3'b000, 0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0);
        match_v = idle_v;
        match_v.pc = 32'h110; match_v.valid = 1'b1;
        match_v.exp_dec = 2'b01; match_v.exp_jump = 1'b1; match_v.exp_targ = 32'h140;
        runVector("bp enter", match_v);
        match_v.exp_dec = 2'b00;
        for (int i = 0; i < 3; i++) begin
            runVector($sformatf("bp hold%0d", i), match_v);
        end
        idle_v.fr = 1'b1; idle_v.exp_targ = 32'h140;
        runVector("bp release", idle_v);

        // Flush during JUMP returns to IDLE even with fetch stalled.
        match_v.exp_dec = 2'b01;
        runVector("flush enter", match_v);
        idle_v.fr = 1'b0; idle_v.flush = 1'b1;
        runVector("flush jump", idle_v);
        idle_v.flush = 1'b0;

        // Reset during JUMP clears everything at once and no redirect returns.
        runVector("rst enter", match_v);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rst jump", 32'(hw_if.hwlp_jump), 32'h0);
        checkOutput("rst kill", 32'(hw_if.hwlp_kill), 32'h0);
        checkOutput("rst targ", hw_if.hwlp_targ_addr, 32'h0);
        checkOutput("rst dec", 32'(hw_if.hwlp_dec_cnt), 32'h0);
        @(negedge clk);
        applyStimulus(idle_v);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post rst jump", 32'(hw_if.hwlp_jump), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("post rst jump2", 32'(hw_if.hwlp_jump), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/cv32e40p_hwloop_ctrl.md
CV32E40P_HWLOOP_CTRL -- requirements
Module: cv32e40p_hwloop_ctrl

Interface
REQ-001 Parameter N_REGS, default 2: number of hardware-loop register sets, with loop 0 as the innermost.
REQ-002 Parameter N_REG_BITS, default $clog2(N_REGS): width of the register-set select.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 pc_id_i  input  32  PC of the instruction currently in ID.
REQ-006 id_valid_i  input  1  instruction in ID retires this cycle; same signal that feeds valid_i of the hwloop register file.
REQ-007 hwlp_start_addr_i / hwlp_end_addr_i / hwlp_counter_i  input  N_REGS x 32 each  current loop register contents.
REQ-008 hwlp_we_i  input  3  register-file write enables {cnt, end, start}.
REQ-009 hwlp_regid_i  input  N_REG_BITS  register set being written.
REQ-010 fetch_ready_i  input  1  IF stage accepts the redirect this cycle.
REQ-011 flush_i  input  1  pipeline flush (exception, debug or interrupt entry).
REQ-012 hwlp_dec_cnt_o  output  N_REGS  per-loop decrement request to the register file.
REQ-013 hwlp_jump_o  output  1  redirect request to IF.
REQ-014 hwlp_targ_addr_o  output  32  redirect target.
REQ-015 hwlp_kill_o  output  1  ID must squash its instruction.

Function
REQ-016 Loop k SHALL match when id_valid_i=1, pc_id_i==hwlp_end_addr_i[k], and hwlp_counter_i[k]!=0.
REQ-017 Matching priority SHALL go to the lowest index: only the lowest-index matching loop is selected, and higher loops are ignored that cycle.
REQ-018 In IDLE, hwlp_dec_cnt_o[k] SHALL be combinational: 1 only for the selected loop k; at most one bit is ever set.
REQ-019 Selected loop with counter>1 SHALL cause a transition IDLE->JUMP at the next edge.
  - On that transition, the target SHALL be registered as hwlp_start_addr_i[k].
REQ-020 Selected loop with counter==1 SHALL be a loop exit: decrement is issued, no jump, and the FSM stays in IDLE.
REQ-021 Write-collision rule: if hwlp_we_i!=0 and hwlp_regid_i==k in the same cycle loop k is selected, hwlp_dec_cnt_o SHALL be all zeros and no jump SHALL be taken.
REQ-022 The FSM SHALL have two states, IDLE and JUMP.
  - In JUMP: hwlp_jump_o=1 and hwlp_kill_o=1, and hwlp_targ_addr_o holds the registered target, stable until exit.
REQ-023 JUMP->IDLE SHALL occur on the edge where fetch_ready_i=1, giving a jump pulse of at least 1 cycle.
REQ-024 While in JUMP, matches SHALL be ignored, with hwlp_dec_cnt_o all zeros.
REQ-025 flush_i=1 SHALL force the FSM to IDLE at the next edge and gate hwlp_dec_cnt_o and the IDLE->JUMP transition that cycle.
  - flush_i SHALL take priority over fetch_ready_i and over a match.
REQ-026 In IDLE, hwlp_jump_o and hwlp_kill_o SHALL be 0; hwlp_targ_addr_o holds its last registered value.
REQ-027 All comparisons SHALL be unsigned 32-bit.
  - The counter==1 and counter>1 tests SHALL use the full 32-bit value, so counter=32'hFFFF_FFFF counts as >1.

Reset
REQ-028 rst_n=0 SHALL immediately force: state IDLE, hwlp_jump_o=0, hwlp_kill_o=0, hwlp_targ_addr_o=32'h0, hwlp_dec_cnt_o=0.
REQ-029 Reset asserted while in JUMP SHALL abandon the pending redirect; no jump reappears after release.

Verification
REQ-030 Basic loop: start0=0x100, end0=0x110, cnt0=3, retire at 0x110.
  - Required: dec0=1 same cycle; jump_o=1 and targ=0x100 next cycle.
  - With fetch_ready_i=1: one-cycle pulse.
  - Repeat until cnt0=1: the final retire decrements with no jump.
REQ-031 Nested, shared end: end0=end1=0x200, cnt0=1, cnt1=5, retire at 0x200.
  - Required: dec=2'b01, no jump.
  - Next retire with cnt0=0: dec=2'b10, jump to start1.
REQ-032 Backpressure: enter JUMP with fetch_ready_i=0 for 3 cycles.
  - Required: jump_o, kill_o and targ stable for 4 cycles.
  - Retire at an end address during that time SHALL give dec=0.
REQ-033 Collision: retire at end0 with hwlp_we_i=3'b100 and regid=0.
  - Required: dec=0 and no jump.
  - Same with regid=1: normal dec0 and jump.
REQ-034 Flush/reset: flush_i in the match cycle gives dec=0 and no jump.
  - flush_i during JUMP gives IDLE next cycle.
  - rst_n low during JUMP gives all outputs 0 immediately.
REQ-035 Inactive loop: cnt0=0 with pc at end0 gives no dec and no jump.
  - cnt0=32'hFFFF_FFFF with pc at end0 gives a jump.
